// File: rtl/alu_seq_pkg.sv
// Shared constants for the 84CP ALU sequencer: ALU function codes and FSM state encodings.
package alu_seq_pkg;

  localparam logic [1:0] FN_SUB   = 2'b00;
  localparam logic [1:0] FN_XOR   = 2'b01;
  localparam logic [1:0] FN_PASSA = 2'b10;
  localparam logic [1:0] FN_PASSB = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/alu_seq.sv
// Sequences 16/32-bit requests through the external 16-bit ALU one half-word per cycle,
// chaining the borrow between halves, and returns a registered result.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter bit LONG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_long,
  input  logic        req_bin,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic [1:0]  alu_func,
  input  logic [15:0] alu_out,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_borrow,
  output logic        rsp_zero,
  output logic [1:0]  fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // req_ready is high only in IDLE, rsp_valid only in RESP, and rsp_* hold until taken.

  logic [1:0]  state;
  logic [1:0]  op;
  logic        long_op;
  logic        bin;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] res;
  logic        brw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      op      <= FN_SUB;
      long_op <= 1'b0;
      bin     <= 1'b0;
      a       <= 32'd0;
      b       <= 32'd0;
      res     <= 32'd0;
      brw     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op      <= req_op;
            long_op <= req_long & LONG_EN;
            bin     <= req_bin;
            a       <= req_a;
            b       <= req_b;
            res     <= 32'd0;
            brw     <= 1'b0;
            state   <= ST_LO;
          end
        end
        ST_LO: begin
          res[15:0] <= alu_out;
          brw       <= alu_cout;
          state     <= long_op ? ST_HI : ST_RESP;
        end
        ST_HI: begin
          res[31:16] <= alu_out;
          brw        <= alu_cout;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ALU pins come from registers only; the high half is shown just during HI.
  assign alu_a    = (state == ST_HI) ? a[31:16] : a[15:0];
  assign alu_b    = (state == ST_HI) ? b[31:16] : b[15:0];
  assign alu_cin  = (state == ST_HI) ? brw : bin;
  assign alu_func = op;

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign rsp_data   = res;
  assign rsp_borrow = brw;
  assign rsp_zero   = (state == ST_RESP) && (long_op ? (res == 32'd0) : (res[15:0] == 16'd0));
  assign fsm_state  = state;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, random ops against a behavioural model,
// backpressure, reset during HI, and a LONG_EN=0 instance.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  int          n_checks;
  int          n_fail;

  // DUT with 32-bit support
  logic        req_valid, req_ready, req_long, req_bin, rsp_valid, rsp_ready, rsp_borrow, rsp_zero;
  logic [1:0]  req_op, alu_func, fsm_state;
  logic [31:0] req_a, req_b, rsp_data;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_cin, alu_cout;

  // DUT with LONG_EN=0
  logic        s_req_valid, s_req_ready, s_req_long, s_req_bin, s_rsp_valid, s_rsp_ready, s_rsp_borrow, s_rsp_zero;
  logic [1:0]  s_req_op, s_alu_func, s_fsm_state;
  logic [31:0] s_req_a, s_req_b, s_rsp_data;
  logic [15:0] s_alu_a, s_alu_b, s_alu_out;
  logic        s_alu_cin, s_alu_cout;

  alu_seq #(.LONG_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_long(req_long), .req_bin(req_bin), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_func(alu_func),
    .alu_out(alu_out), .alu_cout(alu_cout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_borrow(rsp_borrow), .rsp_zero(rsp_zero), .fsm_state(fsm_state)
  );

  alu_seq #(.LONG_EN(1'b0)) dut_s (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(s_req_op),
    .req_long(s_req_long), .req_bin(s_req_bin), .req_a(s_req_a), .req_b(s_req_b),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_cin(s_alu_cin), .alu_func(s_alu_func),
    .alu_out(s_alu_out), .alu_cout(s_alu_cout), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_data(s_rsp_data), .rsp_borrow(s_rsp_borrow), .rsp_zero(s_rsp_zero), .fsm_state(s_fsm_state)
  );

  // External combinational ALU part
  function automatic logic [16:0] alu_f(input logic [1:0] f, input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
    logic [16:0] d;
    case (f)
      2'b00:   d = {1'b0, x} - {1'b0, y} - {16'd0, ci};
      2'b01:   d = {1'b0, x ^ y};
      2'b10:   d = {1'b0, x};
      default: d = {1'b0, y};
    endcase
    return d;
  endfunction

  assign {alu_cout, alu_out}     = alu_f(alu_func, alu_a, alu_b, alu_cin);
  assign {s_alu_cout, s_alu_out} = alu_f(s_alu_func, s_alu_a, s_alu_b, s_alu_cin);

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: whole-word arithmetic at the operation width
  typedef struct packed {
    logic [31:0] data;
    logic        borrow;
    logic        zero;
  } rsp_t;

  function automatic rsp_t ref_model(input logic [1:0] op, input logic lng, input logic bin,
                                     input logic [31:0] x, input logic [31:0] y);
    rsp_t r;
    logic [32:0] d;
    if (!lng) begin
      x = {16'd0, x[15:0]};
      y = {16'd0, y[15:0]};
    end
    case (op)
      2'b00: begin
        d = {1'b0, x} - {1'b0, y} - {32'd0, bin};
        r.data   = lng ? d[31:0] : {16'd0, d[15:0]};
        r.borrow = lng ? d[32] : d[16];
      end
      2'b01: begin r.data = x ^ y; r.borrow = 1'b0; end
      2'b10: begin r.data = x;     r.borrow = 1'b0; end
      default: begin r.data = y;   r.borrow = 1'b0; end
    endcase
    r.zero = (r.data == 32'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait for rsp_valid, sampling on negedges; lat counts cycles since the accept edge.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic lng, input logic bin,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e_data, input logic e_borrow, input logic e_zero, input int e_lat);
    int lat;
    @(negedge clk);
    chk({name, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_long = lng; req_bin = bin; req_a = x; req_b = y;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    chk({name, ".latency"}, lat, e_lat);
    chk({name, ".data"}, rsp_data, e_data);
    chk({name, ".borrow"}, {31'd0, rsp_borrow}, {31'd0, e_borrow});
    chk({name, ".zero"}, {31'd0, rsp_zero}, {31'd0, e_zero});
    @(posedge clk);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        lng;
    logic        bin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_data;
    logic        e_borrow;
    logic        e_zero;
    int          e_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int   lat;
    rsp_t r;
    logic [31:0] held;
    n_checks = 0;
    n_fail   = 0;
    req_valid = 0; req_op = 0; req_long = 0; req_bin = 0; req_a = 0; req_b = 0; rsp_ready = 0;
    s_req_valid = 0; s_req_op = 0; s_req_long = 0; s_req_bin = 0; s_req_a = 0; s_req_b = 0; s_rsp_ready = 0;

    vecs[0] = '{2'b00, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0000_FFFE, 1'b1, 1'b0, 2};
    vecs[1] = '{2'b00, 1'b1, 1'b0, 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 3};
    vecs[2] = '{2'b00, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 3};
    vecs[3] = '{2'b00, 1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0, 3};
    vecs[4] = '{2'b01, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 3};
    vecs[5] = '{2'b10, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hFFFF_0000, 1'b0, 1'b0, 3};
    vecs[6] = '{2'b11, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1'b0, 3};
    vecs[7] = '{2'b01, 1'b0, 1'b0, 32'hFFFF_1234, 32'hAAAA_1234, 32'h0000_0000, 1'b0, 1'b1, 2};
    vecs[8] = '{2'b11, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_8000, 32'h0000_8000, 1'b0, 1'b0, 2};
    vecs[9] = '{2'b01, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 2};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_data", rsp_data, 32'd0);
    chk("rst.rsp_borrow", {31'd0, rsp_borrow}, 32'd0);
    chk("rst.rsp_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst.alu_ab", {alu_a, alu_b}, 32'd0);
    chk("rst.alu_cin_func", {29'd0, alu_cin, alu_func}, 32'd0);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].lng, vecs[i].bin, vecs[i].a, vecs[i].b,
             vecs[i].e_data, vecs[i].e_borrow, vecs[i].e_zero, vecs[i].e_lat);

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic        lng, bin;
      logic [31:0] x, y;
      op  = 2'($urandom_range(0, 3));
      lng = 1'($urandom_range(0, 1));
      bin = 1'($urandom_range(0, 1));
      x   = $urandom;
      y   = (i % 8 == 0) ? x : $urandom;
      r   = ref_model(op, lng, bin, x, y);
      run_op($sformatf("rnd%0d", i), op, lng, bin, x, y, r.data, r.borrow, r.zero, lng ? 3 : 2);
    end

    // Backpressure: result held, second request waits until the cycle after rsp_ready
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b01; req_long = 1'b1; req_bin = 1'b0;
    req_a = 32'hFFFF_0000; req_b = 32'h0F0F_0F0F;
    @(posedge clk);
    #1 req_b = 32'h0000_0001; req_a = 32'h0000_0009; req_op = 2'b00; req_long = 1'b0;
    wait_rsp(lat);
    chk("bp.latency", lat, 3);
    held = rsp_data;
    chk("bp.data", held, 32'hF0F0_0F0F);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp.valid%0d", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp.stable%0d", k), rsp_data, 32'hF0F0_0F0F);
      chk($sformatf("bp.req_ready%0d", k), {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp.taken_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp.idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0; rsp_ready = 1'b1;
    wait_rsp(lat);
    chk("bp2.latency", lat, 2);
    chk("bp2.data", rsp_data, 32'h0000_0008);
    chk("bp2.borrow", {31'd0, rsp_borrow}, 32'd0);
    @(posedge clk);

    // Reset during HI discards the operation
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_long = 1'b1; req_bin = 1'b1;
    req_a = 32'h0000_0000; req_b = 32'h0000_0001; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("hi.alu_a", {16'd0, alu_a}, 32'd0);
    chk("hi.alu_cin", {31'd0, alu_cin}, 32'd1);
    rst = 1'b1;
    #1;
    chk("hirst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("hirst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("hirst.rsp_data", rsp_data, 32'd0);
    chk("hirst.flags", {30'd0, rsp_borrow, rsp_zero}, 32'd0);
    chk("hirst.alu", {alu_a, alu_b}, 32'd0);
    chk("hirst.alu_cf", {29'd0, alu_cin, alu_func}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("hirst.nostray%0d", k), {31'd0, rsp_valid}, 32'd0);
    end

    // LONG_EN=0: long request runs as 16-bit
    @(negedge clk);
    s_req_valid = 1'b1; s_req_op = 2'b00; s_req_long = 1'b1; s_req_bin = 1'b0;
    s_req_a = 32'hABCD_0005; s_req_b = 32'h1234_0007; s_rsp_ready = 1'b1;
    @(posedge clk);
    #1 s_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s_rsp_valid && lat < 20);
    chk("short.latency", lat, 2);
    chk("short.data", s_rsp_data, 32'h0000_FFFE);
    chk("short.borrow", {31'd0, s_rsp_borrow}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("short.idle", {31'd0, s_req_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
